// File: rtl/serial_uart_bridge.sv
// rtl/serial_uart_bridge.sv - UART bridge: TX FIFO plus serialiser, RX deserialiser with one-byte holding register
// Define SERIAL_PARITY_EN for an even parity bit in both directions (11-bit frames).
module serial_uart_bridge #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TX_DEPTH     = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] serial_in,
  input  logic       serial_wren_in,
  output logic       serial_ready_out,
  output logic [7:0] serial_out,
  output logic       serial_valid_out,
  input  logic       serial_rden_in,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       rx_overrun,
  output logic       rx_error
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(TX_DEPTH);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic [7:0]    fifo_mem [TX_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count;
  logic          push, pop;
  logic [7:0]    fifo_head;

  tx_state_t     tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
`ifdef SERIAL_PARITY_EN
  logic          tx_par;
`endif

  rx_state_t     rx_state;
  logic          rx_meta, rx_sync;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_par_bad;
  logic          deliver;

  assign serial_ready_out = (fifo_count != FULL);
  assign push      = serial_wren_in && serial_ready_out;
  assign fifo_head = fifo_mem[rd_ptr];
  // The TX engine pops from idle, or at the end of a stop bit to chain frames gap-free.
  assign pop = (fifo_count != '0) &&
               ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == BIT_LAST));

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= serial_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_txd <= 1'b1;
`ifdef SERIAL_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (pop) begin
      tx_shift <= fifo_head;
`ifdef SERIAL_PARITY_EN
      tx_par   <= ^fifo_head;
`endif
      tx_cnt   <= '0;
      uart_txd <= 1'b0;
      tx_state <= TX_START;
    end else begin
      if (tx_state != TX_IDLE) tx_cnt <= (tx_cnt == BIT_LAST) ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        TX_IDLE: ;
        TX_START: if (tx_cnt == BIT_LAST) begin
          uart_txd <= tx_shift[0];
          tx_shift <= tx_shift >> 1;
          tx_bit   <= '0;
          tx_state <= TX_DATA;
        end
        TX_DATA: if (tx_cnt == BIT_LAST) begin
          if (tx_bit == 3'd7) begin
`ifdef SERIAL_PARITY_EN
            uart_txd <= tx_par;
            tx_state <= TX_PARITY;
`else
            uart_txd <= 1'b1;
            tx_state <= TX_STOP;
`endif
          end else begin
            uart_txd <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
            tx_bit   <= tx_bit + 1'b1;
          end
        end
        TX_PARITY: if (tx_cnt == BIT_LAST) begin
          uart_txd <= 1'b1;
          tx_state <= TX_STOP;
        end
        TX_STOP: if (tx_cnt == BIT_LAST) tx_state <= TX_IDLE;
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_bad <= 1'b0;
      rx_error   <= 1'b0;
    end else begin
      rx_meta <= uart_rxd;
      rx_sync <= rx_meta;
      case (rx_state)
        RX_IDLE: if (!rx_sync) begin
          rx_cnt     <= '0;
          rx_par_bad <= 1'b0;
          rx_state   <= RX_START;
        end
        // Half a bit into the start bit: a high line means it was only a glitch.
        RX_START: if (rx_cnt == HALF_LAST) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_sync ? RX_IDLE : RX_DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_DATA: if (rx_cnt == BIT_LAST) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_sync, rx_shift[7:1]};
          rx_bit   <= rx_bit + 1'b1;
`ifdef SERIAL_PARITY_EN
          if (rx_bit == 3'd7) rx_state <= RX_PARITY;
`else
          if (rx_bit == 3'd7) rx_state <= RX_STOP;
`endif
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_PARITY: if (rx_cnt == BIT_LAST) begin
          rx_cnt <= '0;
          if (rx_sync != ^rx_shift) begin
            rx_par_bad <= 1'b1;
            rx_error   <= 1'b1;
          end
          rx_state <= RX_STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_STOP: if (rx_cnt == BIT_LAST) begin
          rx_cnt <= '0;
          if (rx_sync) rx_state <= RX_IDLE;
          else begin
            rx_error <= 1'b1;
            rx_state <= RX_WAIT_HIGH;
          end
        end else rx_cnt <= rx_cnt + 1'b1;
        RX_WAIT_HIGH: if (rx_sync) rx_state <= RX_IDLE;
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign deliver = (rx_state == RX_STOP) && (rx_cnt == BIT_LAST) && rx_sync && !rx_par_bad;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      serial_out       <= '0;
      serial_valid_out <= 1'b0;
      rx_overrun       <= 1'b0;
    end else if (deliver) begin
      // A coincident read frees the holding register for the new byte.
      if (!serial_valid_out || serial_rden_in) begin
        serial_out       <= rx_shift;
        serial_valid_out <= 1'b1;
      end else rx_overrun <= 1'b1;
    end else if (serial_rden_in) begin
      serial_valid_out <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_uart_bridge.sv
// tb/tb_serial_uart_bridge.sv - randomized scoreboard bench for serial_uart_bridge
module tb_serial_uart_bridge;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;
`ifdef SERIAL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FBITS  = 10 + PAR;
  localparam int FRAME  = FBITS * CPB;
  // Edge count from the first start-bit edge to the stop-bit mid sample (2-FF sync + detect, half bit, data bits).
  localparam int RX_LAT = 2 + CPB / 2 + (9 + PAR) * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] serial_in = '0;
  logic       serial_wren_in = 1'b0;
  logic       serial_ready_out;
  logic [7:0] serial_out;
  logic       serial_valid_out;
  logic       serial_rden_in = 1'b0;
  logic       uart_txd;
  logic       uart_rxd = 1'b1;
  logic       rx_overrun;
  logic       rx_error;

  serial_uart_bridge #(.CLKS_PER_BIT(CPB), .TX_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .serial_in(serial_in), .serial_wren_in(serial_wren_in),
    .serial_ready_out(serial_ready_out), .serial_out(serial_out), .serial_valid_out(serial_valid_out),
    .serial_rden_in(serial_rden_in), .uart_txd(uart_txd), .uart_rxd(uart_rxd),
    .rx_overrun(rx_overrun), .rx_error(rx_error)
  );

  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  typedef struct { logic [7:0] data; int start; } tx_item_t;
  typedef struct { logic [7:0] data; int at; } rx_item_t;
  tx_item_t   tx_exp[$];
  int         tx_pend[$];
  int         last_start = -100000;
  bit         tx_busy = 0;
  rx_item_t   rx_exp[$];
  bit         m_valid = 0;
  logic [7:0] m_byte = '0;
  bit         m_ovr = 0;
  bit         m_err = 0;

  // A byte starts one edge after its push, or when the previous frame ends, whichever is later.
  task automatic tx_write(input logic [7:0] b);
    int e, n;
    tx_item_t it;
    e = cyc + 1;
    while (tx_pend.size() > 0 && tx_pend[0] < e) void'(tx_pend.pop_front());
    n = tx_pend.size();
    check("tx_ready", serial_ready_out, int'(n < DEPTH));
    serial_in = b;
    serial_wren_in = 1'b1;
    if (n < DEPTH) begin
      it.data = b;
      it.start = (e + 1 > last_start + FRAME) ? e + 1 : last_start + FRAME;
      last_start = it.start;
      tx_pend.push_back(it.start);
      tx_exp.push_back(it);
    end
    @(negedge clock);
    serial_wren_in = 1'b0;
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok, input bit rd_at_deliver);
    int n;
    logic [10:0] f;
    rx_item_t it;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = b;
    if (PAR == 1) f[9] = par_ok ? ^b : ~^b;
    f[FBITS-1] = stop_ok;
    n = cyc + 1;
    if (!stop_ok || (PAR == 1 && !par_ok)) m_err = 1;
    else if (!m_valid || rd_at_deliver) begin
      m_valid = 1;
      m_byte = b;
      it.data = b;
      it.at = n + RX_LAT;
      rx_exp.push_back(it);
    end else m_ovr = 1;
    for (int i = 0; i < FBITS; i++) begin
      for (int k = 0; k < CPB; k++) begin
        uart_rxd = f[i];
        serial_rden_in = rd_at_deliver && (cyc + 1 == n + RX_LAT);
        @(negedge clock);
      end
    end
    serial_rden_in = 1'b0;
    uart_rxd = 1'b1;
  endtask

  task automatic rd_pulse();
    serial_rden_in = 1'b1;
    m_valid = 0;
    @(negedge clock);
    serial_rden_in = 1'b0;
  endtask

  task automatic idle(input int n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic check_rx(input string tag);
    check({tag, "_valid"}, serial_valid_out, m_valid);
    check({tag, "_out"}, serial_out, m_byte);
    check({tag, "_overrun"}, rx_overrun, m_ovr);
    check({tag, "_error"}, rx_error, m_err);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_txd"}, uart_txd, 1);
    check({tag, "_ready"}, serial_ready_out, 1);
    check({tag, "_valid"}, serial_valid_out, 0);
    check({tag, "_out"}, serial_out, 0);
    check({tag, "_overrun"}, rx_overrun, 0);
    check({tag, "_error"}, rx_error, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    uart_rxd = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check_idle("reset");
    tx_exp.delete();
    tx_pend.delete();
    rx_exp.delete();
    last_start = -100000;
    m_valid = 0;
    m_byte = '0;
    m_ovr = 0;
    m_err = 0;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 4000 && (tx_exp.size() > 0 || tx_busy); t++) @(negedge clock);
    check({tag, "_tx_drain"}, tx_exp.size() + int'(tx_busy), 0);
    check({tag, "_rx_drain"}, rx_exp.size(), 0);
  endtask

  function automatic logic [7:0] fresh_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == m_byte) b = b ^ 8'h80;
    return b;
  endfunction

  initial begin : tx_mon
    tx_item_t it;
    logic [10:0] got, exp_f;
    bit aborted;
    forever begin
      @(negedge clock);
      if (!reset && uart_txd === 1'b0) begin
        tx_busy = 1;
        aborted = 0;
        got = '1;
        if (tx_exp.size() > 0) it = tx_exp.pop_front();
        else begin
          it.data = '0;
          it.start = -1;
        end
        check("tx_frame_start", cyc, it.start);
        for (int i = 0; i < FBITS; i++) begin
          repeat (i == 0 ? CPB / 2 : CPB) @(negedge clock);
          if (reset) aborted = 1;
          got[i] = uart_txd;
        end
        exp_f = '1;
        exp_f[0] = 1'b0;
        exp_f[8:1] = it.data;
        if (PAR == 1) exp_f[9] = ^it.data;
        exp_f[FBITS-1] = 1'b1;
        if (!aborted) check("tx_frame_bits", got[FBITS-1:0], exp_f[FBITS-1:0]);
        tx_busy = 0;
      end
    end
  end

  initial begin : rx_mon
    logic pv;
    logic [7:0] po;
    rx_item_t it;
    pv = 0;
    po = '0;
    forever begin
      @(negedge clock);
      if (reset) pv = 0;
      else begin
        if (serial_valid_out && (!pv || serial_out != po)) begin
          if (rx_exp.size() > 0) it = rx_exp.pop_front();
          else begin
            it.data = serial_out;
            it.at = -1;
          end
          check("rx_deliver_byte", serial_out, it.data);
          check("rx_deliver_cycle", cyc, it.at);
        end
        pv = serial_valid_out;
        po = serial_out;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    @(negedge clock);
    do_reset();

    tx_write(8'hA5);
    for (int i = 1; i <= 6; i++) tx_write(8'(i));

    rx_frame(8'h3C, 1, 1, 0);
    idle(4);
    check_rx("t3_deliver");
    rd_pulse();
    check_rx("t3_read");

    drain("t2");
    rx_frame(8'h11, 1, 1, 0);
    idle(4);
    rx_frame(8'h22, 1, 1, 0);
    idle(4);
    check_rx("t4_overrun");
    do_reset();
    rx_frame(8'h11, 1, 1, 0);
    idle(4);
    rx_frame(8'h22, 1, 1, 1);
    idle(4);
    check_rx("t4_coincident");

    rd_pulse();
    uart_rxd = 1'b0;
    repeat (2) @(negedge clock);
    idle(20);
    check_rx("t5_glitch");
    rx_frame(8'h00, 0, 1, 0);
    idle(6);
    check_rx("t5_framing");
    rx_frame(8'h5E, 1, 1, 0);
    idle(4);
    check_rx("t5_recover");

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 6))
        0, 1: begin
          n = $urandom_range(1, 6);
          for (int k = 0; k < n; k++) begin
            tx_write(8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clock);
          end
        end
        2, 3: rx_frame(fresh_byte(), 1, 1, 0);
        4: rx_frame(fresh_byte(), 1, 1, 1);
        5: rd_pulse();
        default: begin
          if ($urandom_range(0, 1) == 1) rx_frame(8'($urandom), 0, 1, 0);
          else begin
            uart_rxd = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clock);
            idle(16);
          end
        end
      endcase
      idle($urandom_range(4, 12));
      check_rx("rand");
    end
    drain("rand");

    rx_frame(8'h44, 0, 1, 0);
    idle(6);
    tx_write(8'hC3);
    fork
      rx_frame(8'h5A, 1, 1, 0);
      begin
        repeat (30) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check_idle("midframe_reset");
      end
    join
    do_reset();

`ifdef SERIAL_PARITY_EN
    tx_write(8'h03);
    rx_frame(8'h01, 1, 0, 0);
    idle(6);
    check_rx("parity_bad");
    rx_frame(8'h81, 1, 1, 0);
    idle(4);
    check_rx("parity_good");
`endif
    rx_frame(8'h96, 1, 1, 0);
    idle(4);
    check_rx("final");
    drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
